hex_sum_accum: RTL and testbench

HEX_SUM_ACCUM -- requirements
Module: hex_sum_accum

---
 rtl/hex_sum_accum.sv | 122 ++++++++++++
 tb/tb_hex_sum_accum.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/hex_sum_accum.sv
// hex_sum_accum: run-based accumulator with a seven-segment image of the result.
//
// A run starts when go_l is sampled low in IDLE. Each following cycle one
// term is sampled from inA; nonzero terms are added (mod 2^WIDTH) and counted.
// The run ends on a zero term or on the term that brings count to MAX_TERMS.
// The DONE cycle pulses done, and hex is loaded with the final sum at that moment.
//
// Ports
//   ck        : clock, rising edge
//   reset     : synchronous active-high reset
//   go_l      : active-low run request (looked at only in IDLE)
//   inA       : term stream (looked at only in ACCUM)
//   sum       : running / final sum
//   done      : one-cycle pulse, final sum valid
//   overflow  : sticky carry-out for the current run
//   count     : number of nonzero terms added in the current run
//   hex       : active-low segments {a..g} per nibble; hex[6:0] = LS nibble
module hex_sum_accum #(
  parameter int WIDTH     = 8,
  parameter int MAX_TERMS = 16,
  localparam int DIGITS   = WIDTH / 4,
  localparam int CW       = $clog2(MAX_TERMS + 1)
) (
  input  logic                ck,
  input  logic                reset,
  input  logic                go_l,
  input  logic [WIDTH-1:0]    inA,
  output logic [WIDTH-1:0]    sum,
  output logic                done,
  output logic                overflow,
  output logic [CW-1:0]       count,
  output logic [7*DIGITS-1:0] hex
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0001100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  function automatic logic [7*DIGITS-1:0] to_hex(input logic [WIDTH-1:0] v);
    logic [7*DIGITS-1:0] r;
    r = '0;
    for (int d = 0; d < DIGITS; d++)
      r[7*d +: 7] = seg7(v[4*d +: 4]);
    return r;
  endfunction

  // Next-sum with carry and next count, used only when a term is added.
  logic [WIDTH:0]  add_full;
  logic [CW-1:0]   count_inc;
  assign add_full  = {1'b0, sum} + {1'b0, inA};
  assign count_inc = count + CW'(1);

  always_ff @(posedge ck) begin
    if (reset) begin
      state    <= IDLE;
      sum      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      hex      <= to_hex('0);
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (!go_l) begin
            sum      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (inA != '0) begin
            sum      <= add_full[WIDTH-1:0];
            count    <= count_inc;
            overflow <= overflow | add_full[WIDTH];
            // Hitting the term limit ends the run on the same edge as the add.
            if (count_inc == CW'(MAX_TERMS)) begin
              state <= DONE;
              done  <= 1'b1;
              hex   <= to_hex(add_full[WIDTH-1:0]);
            end
          end else begin
            state <= DONE;
            done  <= 1'b1;
            hex   <= to_hex(sum);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_sum_accum.sv
// Directed bench for hex_sum_accum (WIDTH=8, MAX_TERMS=4). Inputs change
// 1ns after a rising edge; outputs are checked at that same point.
module tb_hex_sum_accum;

  localparam int WIDTH = 8;
  localparam int MAX_TERMS = 4;
  localparam int CW = $clog2(MAX_TERMS + 1);

  logic             ck = 1'b0;
  logic             reset;
  logic             go_l;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] sum;
  logic             done;
  logic             overflow;
  logic [CW-1:0]    count;
  logic [13:0]      hex;

  int n_asrt = 0;
  int n_fail = 0;

  // Hand-encoded digit images, upper nibble first.
  localparam logic [13:0] HEX_00 = {7'b0000001, 7'b0000001};
  localparam logic [13:0] HEX_0F = {7'b0000001, 7'b0111000};
  localparam logic [13:0] HEX_10 = {7'b1001111, 7'b0000001};
  localparam logic [13:0] HEX_04 = {7'b0000001, 7'b1001100};
  localparam logic [13:0] HEX_06 = {7'b0000001, 7'b0100000};

  hex_sum_accum #(.WIDTH(WIDTH), .MAX_TERMS(MAX_TERMS)) dut (
    .ck(ck), .reset(reset), .go_l(go_l), .inA(inA),
    .sum(sum), .done(done), .overflow(overflow), .count(count), .hex(hex)
  );

  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_sum, input logic [2:0] e_cnt,
                         input logic e_ovf, input logic e_done);
    chk({tag, ".sum"},  32'(sum),      32'(e_sum));
    chk({tag, ".cnt"},  32'(count),    32'(e_cnt));
    chk({tag, ".ovf"},  32'(overflow), 32'(e_ovf));
    chk({tag, ".done"}, 32'(done),     32'(e_done));
  endtask

  initial begin
    reset = 1'b1; go_l = 1'b1; inA = '0;
    tick(); tick();
    chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    chk("reset.hex", 32'(hex), 32'(HEX_00));
    reset = 1'b0;

    // Run 1: 3,5,7,0
    go_l = 1'b0; tick();
    go_l = 1'b1; inA = 8'd3; tick();
    chk_out("r1.t1", 8'h03, 3'd1, 1'b0, 1'b0);
    inA = 8'd5; tick();
    chk_out("r1.t2", 8'h08, 3'd2, 1'b0, 1'b0);
    inA = 8'd7; tick();
    chk_out("r1.t3", 8'h0F, 3'd3, 1'b0, 1'b0);
    chk("r1.hex_pre", 32'(hex), 32'(HEX_00));
    inA = 8'd0; tick();
    chk_out("r1.done", 8'h0F, 3'd3, 1'b0, 1'b1);
    chk("r1.hex", 32'(hex), 32'(HEX_0F));
    inA = 8'h55; tick();
    chk_out("r1.idle", 8'h0F, 3'd3, 1'b0, 1'b0);
    tick();
    chk_out("r1.hold", 8'h0F, 3'd3, 1'b0, 1'b0);

    // Run 2: F0,20,0 -> wraps to 0x10 with overflow
    go_l = 1'b0; inA = 8'd0; tick();
    chk_out("r2.start", 8'h00, 3'd0, 1'b0, 1'b0);
    chk("r2.hex_hold", 32'(hex), 32'(HEX_0F));
    go_l = 1'b1; inA = 8'hF0; tick();
    chk_out("r2.t1", 8'hF0, 3'd1, 1'b0, 1'b0);
    inA = 8'h20; tick();
    chk_out("r2.t2", 8'h10, 3'd2, 1'b1, 1'b0);
    inA = 8'd0; tick();
    chk_out("r2.done", 8'h10, 3'd2, 1'b1, 1'b1);
    chk("r2.hex", 32'(hex), 32'(HEX_10));
    tick();
    chk_out("r2.idle", 8'h10, 3'd2, 1'b1, 1'b0);

    // Run 3: 1,1,1,1,9 -> limit after the 4th term
    go_l = 1'b0; tick();
    chk("r3.ovf_clr", 32'(overflow), 32'd0);
    go_l = 1'b1; inA = 8'd1; tick(); tick(); tick();
    chk_out("r3.t3", 8'h03, 3'd3, 1'b0, 1'b0);
    tick();
    chk_out("r3.done", 8'h04, 3'd4, 1'b0, 1'b1);
    chk("r3.hex", 32'(hex), 32'(HEX_04));
    inA = 8'd9; tick();
    chk_out("r3.idle", 8'h04, 3'd4, 1'b0, 1'b0);
    tick();
    chk_out("r3.hold", 8'h04, 3'd4, 1'b0, 1'b0);

    // Run 4: reset mid-accumulation
    go_l = 1'b0; inA = 8'd0; tick();
    go_l = 1'b1; inA = 8'd2; tick();
    inA = 8'd3; tick();
    chk_out("r4.t2", 8'h05, 3'd2, 1'b0, 1'b0);
    reset = 1'b1; inA = 8'd0; tick();
    chk_out("r4.rst", 8'h00, 3'd0, 1'b0, 1'b0);
    chk("r4.hex", 32'(hex), 32'(HEX_00));
    reset = 1'b0; tick();
    chk("r4.nodone1", 32'(done), 32'd0);
    tick();
    chk("r4.nodone2", 32'(done), 32'd0);

    // Run 5: go_l held low, first term zero, then a back-to-back run
    go_l = 1'b0; inA = 8'd0; tick();
    tick();
    chk_out("r5.done", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    chk("r5.idle_done", 32'(done), 32'd0);
    inA = 8'd6; tick();
    chk_out("r6.start", 8'h00, 3'd0, 1'b0, 1'b0);
    go_l = 1'b1; tick();
    chk_out("r6.t1", 8'h06, 3'd1, 1'b0, 1'b0);
    chk("r6.hex_hold", 32'(hex), 32'(HEX_00));
    inA = 8'd0; tick();
    chk_out("r6.done", 8'h06, 3'd1, 1'b0, 1'b1);
    chk("r6.hex", 32'(hex), 32'(HEX_06));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
